uart_tx: RTL and testbench
==========================

# uart_tx

Serial UART transmitter that drains the hardware-register UART TX byte FIFO and drives the board TXD pin. It waits for the FIFO to report data, serialises one byte per frame as 8N1, or 8E1 when parity is compiled in. At the end of each frame it pulses a completion strobe that pops the FIFO. It sits between the hwregs TX FIFO outputs (`uart_tx_valid`, `uart_tx_data`, `uart_tx_complete`) and the top-level pin.

## Interface
Parameters:
- CLKS_PER_BIT, 434, clock cycles per bit period (50 MHz / 115200); legal range 2..65535
- STOP_BITS, 1, number of stop bits; 1 or 2

Ports:
- clock  input  1  system clock
- reset  input  1  reset; asynchronous, active-high
- uart_tx_valid  input  1  FIFO not-empty; a byte is waiting
- uart_tx_data  input  8  byte at FIFO head; show-ahead, stable while valid
- uart_tx_complete  output  1  one-cycle pulse at end of frame; pops the FIFO
- uart_txd  output  1  serial line, idle high
- busy  output  1  high while a frame is in progress (any state other than IDLE)

## Operation
- All outputs are registered.
- Reset values: uart_txd=1, uart_tx_complete=0, busy=0, state=IDLE, all counters=0.
- States:
  - IDLE: uart_txd=1. If uart_tx_valid=1, latch uart_tx_data into the shift register, clear the bit counter and baud counter, and go to START.
  - START: uart_txd=0 for CLKS_PER_BIT cycles, then go to DATA.
  - DATA: shift out 8 bits, LSB first, each held for CLKS_PER_BIT cycles. After bit 7, go to PARITY if it is compiled in, otherwise STOP.
  - PARITY: uart_txd = XOR of the 8 latched bits, held for CLKS_PER_BIT cycles, then go to STOP.
  - STOP: uart_txd=1 for STOP_BITS×CLKS_PER_BIT cycles, then go to DONE.
  - DONE: uart_txd=1, uart_tx_complete=1 for exactly this one cycle, then go to IDLE.
- The FIFO pops on the clock edge that ends DONE. IDLE therefore samples the updated head, and no byte is ever sent twice.
- The data byte is latched at the IDLE→START transition. Changes on uart_tx_data mid-frame are ignored.
- Counter widths:
  - Baud counter: $clog2(CLKS_PER_BIT) bits. It counts 0..CLKS_PER_BIT-1 and wraps on each bit boundary.
  - Bit counter: 3 bits.
  - Stop counter: 1 bit.
- uart_tx_valid is ignored in every state except IDLE.
- Reset mid-frame: uart_txd goes high immediately (asynchronously), the frame is abandoned, and no complete pulse is issued. The FIFO shares the same reset and is emptied with it.

## Timing
- Let T be the IDLE cycle in which valid=1 is sampled. The start bit drives uart_txd low from T+1 through T+CLKS_PER_BIT.
- Data bit n occupies cycles T+1+(n+1)·CLKS_PER_BIT through T+(n+2)·CLKS_PER_BIT.
- Frame length is F = (10 + P + STOP_BITS − 1)·CLKS_PER_BIT cycles, where P = 1 if parity is compiled in, else 0.
- DONE, and the complete pulse, occur at cycle T+F+1.
- Back-to-back bytes: the next sample happens at T+F+2, so the start-to-start period is F+2 cycles. The line stays high for 2 extra cycles beyond the stop bit(s).
- Latency from valid rising (block idle) to first start-bit cycle: 1 cycle.

## Configuration
- UART_TX_PARITY_EN defined: the PARITY state is compiled in, frames are 8E1 (8 data bits, even parity, 1 stop bit, or 2 stop bits with STOP_BITS=2), and P=1.
- UART_TX_PARITY_EN undefined: the PARITY state and parity logic are absent, frames are 8N1, and DATA goes directly to STOP.

## Structure
- Package uart_pkg holds:
  - the state enum (IDLE, START, DATA, PARITY, STOP, DONE);
  - constant DEFAULT_CLKS_PER_BIT = 434;
  - constant UART_DATA_BITS = 8.
- One sub-module is natural: uart_baud_gen. It is a cleared-on-start counter emitting a one-cycle bit_tick every CLKS_PER_BIT cycles. It is reusable by a future uart_rx.

## Test plan
Bench uses CLKS_PER_BIT=4 and STOP_BITS=1 unless stated otherwise.
- Idle: hold uart_tx_valid=0 for 100 cycles → uart_txd=1, busy=0, no complete pulse.
- Single byte 0x55, parity off: line reads 0,1,0,1,0,1,0,1,0,1, each level held 4 cycles. Complete pulses once, 41 cycles after the valid sample.
- Back-to-back 0x41 then 0x42 from a FIFO model: 2 frames decode to 0x41, 0x42. Start-to-start distance is 42 cycles, with exactly 2 complete pulses and no duplicate byte.
- Parity: with UART_TX_PARITY_EN, send 0x07 → parity bit is 1. With UART_TX_PARITY_EN, send 0x03 → parity bit is 0. Each frame length is 44 cycles to DONE.
- STOP_BITS=2, send 0xA5 → stop high for 8 cycles, then the complete pulse. Decoded byte is 0xA5.
- Reset asserted during bit 3 of 0xF0 → uart_txd=1 in the same cycle, busy=0, no complete pulse. The next byte 0x12 after release transmits correctly.

Source files
------------

// File: rtl/uart_pkg.sv
// -----------------------------------------------------------------------------
// uart_pkg
// Shared definitions for the UART blocks: FSM state encoding, default baud
// divisor (50 MHz / 115200) and the data-bit count of a frame.
// -----------------------------------------------------------------------------
package uart_pkg;

  localparam int DEFAULT_CLKS_PER_BIT = 434;
  localparam int UART_DATA_BITS       = 8;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    START  = 3'd1,
    DATA   = 3'd2,
    PARITY = 3'd3,
    STOP   = 3'd4,
    DONE   = 3'd5
  } uart_state_e;

endpackage

// File: rtl/uart_baud_gen.sv
// -----------------------------------------------------------------------------
// uart_baud_gen
// Bit-period timer. While clear_i is high the counter is held at zero; once
// released it counts 0..CLKS_PER_BIT-1 and wraps, pulsing bit_tick_o for one
// cycle on the last count of every bit period. Shared with a future uart_rx.
//
// Ports:
//   clock       system clock
//   reset       asynchronous active-high reset
//   clear_i     hold counter at zero (asserted while the line is idle)
//   bit_tick_o  one-cycle pulse on the final cycle of each bit period
// -----------------------------------------------------------------------------
module uart_baud_gen
  import uart_pkg::*;
#(
  parameter int CLKS_PER_BIT = DEFAULT_CLKS_PER_BIT
) (
  input  logic clock,
  input  logic reset,
  input  logic clear_i,
  output logic bit_tick_o
);

  localparam int CNT_W = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CLKS_PER_BIT - 1);

  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clear_i || (cnt_q == CNT_LAST)) begin
      cnt_d = '0;
    end else begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign bit_tick_o = !clear_i && (cnt_q == CNT_LAST);

endmodule

// File: rtl/uart_tx.sv
// -----------------------------------------------------------------------------
// uart_tx
// Serial transmitter draining a show-ahead TX byte FIFO onto the TXD pin.
// Frames are 8N1 by default, or 8E1 when UART_TX_PARITY_EN is defined.
// STOP_BITS selects one or two stop bits. A one-cycle uart_tx_complete pulse
// at the end of each frame pops the FIFO.
//
// Optional feature macro: UART_TX_PARITY_EN (adds an even-parity bit).
//
// Ports:
//   clock             system clock
//   reset             asynchronous active-high reset
//   uart_tx_valid     FIFO not empty (only looked at in IDLE)
//   uart_tx_data      byte at FIFO head, latched when a frame starts
//   uart_tx_complete  one-cycle end-of-frame pulse (FIFO pop)
//   uart_txd          serial line, idle high
//   busy              high while a frame is in progress
// -----------------------------------------------------------------------------
module uart_tx
  import uart_pkg::*;
#(
  parameter int CLKS_PER_BIT = DEFAULT_CLKS_PER_BIT,
  parameter int STOP_BITS    = 1
) (
  input  logic                      clock,
  input  logic                      reset,
  input  logic                      uart_tx_valid,
  input  logic [UART_DATA_BITS-1:0] uart_tx_data,
  output logic                      uart_tx_complete,
  output logic                      uart_txd,
  output logic                      busy
);

  localparam logic [2:0] BIT_LAST  = 3'(UART_DATA_BITS - 1);
  localparam logic       STOP_LAST = 1'(STOP_BITS - 1);

  uart_state_e               state_q, state_d;
  logic [UART_DATA_BITS-1:0] shift_q, shift_d;
  logic [2:0]                bit_cnt_q, bit_cnt_d;
  logic                      stop_cnt_q, stop_cnt_d;
  logic                      txd_q, txd_d;
  logic                      complete_q, complete_d;
  logic                      busy_q, busy_d;
  logic                      bit_tick;
`ifdef UART_TX_PARITY_EN
  logic                      parity_q, parity_d;
`endif

  // Counter is held at zero in IDLE so the start bit gets a full period.
  uart_baud_gen #(
    .CLKS_PER_BIT(CLKS_PER_BIT)
  ) u_baud_gen (
    .clock     (clock),
    .reset     (reset),
    .clear_i   (state_q == IDLE),
    .bit_tick_o(bit_tick)
  );

  always_comb begin
    state_d    = state_q;
    shift_d    = shift_q;
    bit_cnt_d  = bit_cnt_q;
    stop_cnt_d = stop_cnt_q;
`ifdef UART_TX_PARITY_EN
    parity_d   = parity_q;
`endif

    case (state_q)
      IDLE: begin
        if (uart_tx_valid) begin
          shift_d    = uart_tx_data;
          bit_cnt_d  = '0;
          stop_cnt_d = 1'b0;
`ifdef UART_TX_PARITY_EN
          parity_d   = ^uart_tx_data;
`endif
          state_d    = START;
        end
      end
      START: begin
        if (bit_tick) state_d = DATA;
      end
      DATA: begin
        if (bit_tick) begin
          shift_d   = {1'b0, shift_q[UART_DATA_BITS-1:1]};
          bit_cnt_d = bit_cnt_q + 3'd1;
          if (bit_cnt_q == BIT_LAST) begin
`ifdef UART_TX_PARITY_EN
            state_d = PARITY;
`else
            state_d = STOP;
`endif
          end
        end
      end
`ifdef UART_TX_PARITY_EN
      PARITY: begin
        if (bit_tick) state_d = STOP;
      end
`endif
      STOP: begin
        if (bit_tick) begin
          if (stop_cnt_q == STOP_LAST) begin
            state_d = DONE;
          end else begin
            stop_cnt_d = stop_cnt_q + 1'b1;
          end
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    // Outputs are registered from the next state so the pin changes on the
    // same edge as the state (start bit appears one cycle after valid sample).
    txd_d = 1'b1;
    case (state_d)
      START:   txd_d = 1'b0;
      DATA:    txd_d = shift_d[0];
`ifdef UART_TX_PARITY_EN
      PARITY:  txd_d = parity_d;
`endif
      default: txd_d = 1'b1;
    endcase
    complete_d = (state_d == DONE);
    busy_d     = (state_d != IDLE);
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q    <= IDLE;
      shift_q    <= '0;
      bit_cnt_q  <= '0;
      stop_cnt_q <= 1'b0;
      txd_q      <= 1'b1;
      complete_q <= 1'b0;
      busy_q     <= 1'b0;
`ifdef UART_TX_PARITY_EN
      parity_q   <= 1'b0;
`endif
    end else begin
      state_q    <= state_d;
      shift_q    <= shift_d;
      bit_cnt_q  <= bit_cnt_d;
      stop_cnt_q <= stop_cnt_d;
      txd_q      <= txd_d;
      complete_q <= complete_d;
      busy_q     <= busy_d;
`ifdef UART_TX_PARITY_EN
      parity_q   <= parity_d;
`endif
    end
  end

  assign uart_txd         = txd_q;
  assign uart_tx_complete = complete_q;
  assign busy             = busy_q;

endmodule

// File: tb/tb_uart_tx.sv
// -----------------------------------------------------------------------------
// tb_uart_tx
// Scoreboard bench for uart_tx. Two instances share clock and reset:
// dut_a (STOP_BITS=1) and dut_b (STOP_BITS=2), both with CLKS_PER_BIT=4.
// Each is fed from a FIFO model that pops on uart_tx_complete; bytes are
// pushed to an expected queue when queued and popped by a line decoder.
// -----------------------------------------------------------------------------
module tb_uart_tx;

  localparam int C = 4;
`ifdef UART_TX_PARITY_EN
  localparam int P = 1;
`else
  localparam int P = 0;
`endif

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       valid_a = 1'b0, valid_b = 1'b0;
  logic [7:0] data_a = 8'h00, data_b = 8'h00;
  logic       cpl_a, txd_a, busy_a;
  logic       cpl_b, txd_b, busy_b;

  int n_tests  = 0;
  int n_fail   = 0;
  int cyc      = 0;
  int pulses_a = 0;
  int pulses_b = 0;

  logic mon_en_a = 1'b0;
  logic mon_en_b = 1'b0;

  logic [7:0] fifo_a[$];
  logic [7:0] fifo_b[$];
  logic [7:0] exp_a[$];
  logic [7:0] exp_b[$];
  int         starts_a[$];

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  uart_tx #(.CLKS_PER_BIT(C), .STOP_BITS(1)) u_dut_a (
    .clock           (clk),
    .reset           (rst),
    .uart_tx_valid   (valid_a),
    .uart_tx_data    (data_a),
    .uart_tx_complete(cpl_a),
    .uart_txd        (txd_a),
    .busy            (busy_a)
  );

  uart_tx #(.CLKS_PER_BIT(C), .STOP_BITS(2)) u_dut_b (
    .clock           (clk),
    .reset           (rst),
    .uart_tx_valid   (valid_b),
    .uart_tx_data    (data_b),
    .uart_tx_complete(cpl_b),
    .uart_txd        (txd_b),
    .busy            (busy_b)
  );

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  function automatic logic line_of(input int w);
    return (w == 0) ? txd_a : txd_b;
  endfunction
  function automatic logic cpl_of(input int w);
    return (w == 0) ? cpl_a : cpl_b;
  endfunction
  function automatic logic busy_of(input int w);
    return (w == 0) ? busy_a : busy_b;
  endfunction
  function automatic logic en_of(input int w);
    return (w == 0) ? mon_en_a : mon_en_b;
  endfunction

  // FIFO models: show-ahead head, popped by the complete pulse, emptied by reset.
  initial forever begin
    @(negedge clk);
    if (rst) begin
      fifo_a.delete();
      fifo_b.delete();
    end else begin
      if (cpl_a && fifo_a.size() != 0) void'(fifo_a.pop_front());
      if (cpl_b && fifo_b.size() != 0) void'(fifo_b.pop_front());
    end
    if (cpl_a) pulses_a++;
    if (cpl_b) pulses_b++;
    valid_a = (fifo_a.size() != 0);
    data_a  = valid_a ? fifo_a[0] : 8'h00;
    valid_b = (fifo_b.size() != 0);
    data_b  = valid_b ? fifo_b[0] : 8'h00;
  end

  // Line decoder: every cycle of each bit is checked, complete must be low
  // throughout the frame and high exactly on the cycle after the stop bits.
  task automatic monitor(input int w);
    int         sb;
    int         t0;
    logic [7:0] b;
    logic [7:0] e;
    logic       pbit;
    logic       bad;
    sb = (w == 0) ? 1 : 2;
    forever begin
      @(negedge clk);
      if (!rst && en_of(w) && line_of(w) == 1'b0) begin
        t0   = cyc;
        bad  = !busy_of(w) || cpl_of(w);
        b    = 8'h00;
        pbit = 1'b0;
        for (int i = 1; i < C; i++) begin
          @(negedge clk);
          if (line_of(w) !== 1'b0 || !busy_of(w) || cpl_of(w)) bad = 1'b1;
        end
        for (int n = 0; n < 8; n++) begin
          for (int i = 0; i < C; i++) begin
            @(negedge clk);
            if (i == 0) b[n] = line_of(w);
            else if (line_of(w) !== b[n]) bad = 1'b1;
            if (!busy_of(w) || cpl_of(w)) bad = 1'b1;
          end
        end
        for (int i = 0; i < P * C; i++) begin
          @(negedge clk);
          if (i == 0) pbit = line_of(w);
          else if (line_of(w) !== pbit) bad = 1'b1;
          if (!busy_of(w) || cpl_of(w)) bad = 1'b1;
        end
        for (int i = 0; i < sb * C; i++) begin
          @(negedge clk);
          if (line_of(w) !== 1'b1 || !busy_of(w) || cpl_of(w)) bad = 1'b1;
        end
        @(negedge clk);
        check_eq($sformatf("dut%0d_done_pulse", w), {31'b0, cpl_of(w)}, 32'd1);
        check_eq($sformatf("dut%0d_done_line", w), {31'b0, line_of(w)}, 32'd1);
        check_eq($sformatf("dut%0d_sb_pending", w),
                 {31'b0, ((w == 0) ? exp_a.size() : exp_b.size()) != 0}, 32'd1);
        e = 8'h00;
        if (w == 0 && exp_a.size() != 0) e = exp_a.pop_front();
        if (w == 1 && exp_b.size() != 0) e = exp_b.pop_front();
        if (P == 1 && pbit !== ^e) bad = 1'b1;
        check_eq($sformatf("dut%0d_byte", w), {24'b0, b}, {24'b0, e});
        check_eq($sformatf("dut%0d_frame_shape", w), {31'b0, bad}, 32'd0);
        $display("[TB] dut%0d frame byte=0x%02h expected=0x%02h start_cyc=%0d", w, b, e, t0);
        if (w == 0) starts_a.push_back(t0);
        @(negedge clk);
        check_eq($sformatf("dut%0d_idle_after_done", w),
                 {30'b0, busy_of(w), cpl_of(w)}, 32'd0);
      end
    end
  endtask

  initial monitor(0);
  initial monitor(1);

  task automatic send_a(input logic [7:0] b);
    @(negedge clk);
    fifo_a.push_back(b);
    exp_a.push_back(b);
  endtask

  task automatic send_b(input logic [7:0] b);
    @(negedge clk);
    fifo_b.push_back(b);
    exp_b.push_back(b);
  endtask

  task automatic drain(input string tag);
    logic ok;
    ok = 1'b0;
    for (int i = 0; i < 2000 && !ok; i++) begin
      @(negedge clk);
      if (fifo_a.size() == 0 && fifo_b.size() == 0 && exp_a.size() == 0 &&
          exp_b.size() == 0 && !busy_a && !busy_b) ok = 1'b1;
    end
    check_eq(tag, {31'b0, ok}, 32'd1);
    repeat (3) @(negedge clk);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    int   p0;
    int   s0;
    logic idle_ok;
    logic got;

    // Reset state
    rst = 1'b1;
    repeat (3) @(negedge clk);
    check_eq("reset_txd_a", {31'b0, txd_a}, 32'd1);
    check_eq("reset_cpl_busy_a", {30'b0, cpl_a, busy_a}, 32'd0);
    check_eq("reset_outputs_b", {29'b0, txd_b, cpl_b, busy_b}, 32'd4);
    rst = 1'b0;

    // Idle: no valid for 100 cycles
    idle_ok = 1'b1;
    repeat (100) begin
      @(negedge clk);
      if (txd_a !== 1'b1 || busy_a || cpl_a || txd_b !== 1'b1 || busy_b || cpl_b) idle_ok = 1'b0;
    end
    check_eq("idle_quiet", {31'b0, idle_ok}, 32'd1);
    check_eq("idle_no_pulse", pulses_a + pulses_b, 32'd0);

    mon_en_a = 1'b1;
    mon_en_b = 1'b1;

    // Single byte
    p0 = pulses_a;
    send_a(8'h55);
    drain("drain_0x55");
    check_eq("pulses_0x55", pulses_a - p0, 32'd1);

    // Back-to-back bytes
    p0 = pulses_a;
    s0 = starts_a.size();
    send_a(8'h41);
    send_a(8'h42);
    drain("drain_b2b");
    check_eq("pulses_b2b", pulses_a - p0, 32'd2);
    check_eq("frames_b2b", starts_a.size() - s0, 32'd2);
    if (starts_a.size() >= s0 + 2)
      check_eq("start_to_start", starts_a[s0 + 1] - starts_a[s0], (10 + P) * C + 2);

    // Parity patterns (odd and even weight)
    send_a(8'h07);
    send_a(8'h03);
    drain("drain_parity");

    // Two stop bits
    p0 = pulses_b;
    send_b(8'hA5);
    drain("drain_stop2");
    check_eq("pulses_stop2", pulses_b - p0, 32'd1);

    // Reset during bit 3 of 0xF0
    mon_en_a = 1'b0;
    p0 = pulses_a;
    @(negedge clk);
    fifo_a.push_back(8'hF0);
    got = 1'b0;
    for (int i = 0; i < 20 && !got; i++) begin
      @(negedge clk);
      if (txd_a == 1'b0) got = 1'b1;
    end
    check_eq("rst_frame_started", {31'b0, got}, 32'd1);
    repeat (4 * C + 1) @(negedge clk);
    check_eq("rst_pre_line_bit3", {31'b0, txd_a}, 32'd0);
    rst = 1'b1;
    #1;
    check_eq("rst_line_async", {31'b0, txd_a}, 32'd1);
    check_eq("rst_busy_cpl", {30'b0, busy_a, cpl_a}, 32'd0);
    repeat (3) @(negedge clk);
    rst = 1'b0;
    idle_ok = 1'b1;
    repeat (60) begin
      @(negedge clk);
      if (txd_a !== 1'b1 || busy_a) idle_ok = 1'b0;
    end
    check_eq("rst_abandoned", {31'b0, idle_ok}, 32'd1);
    check_eq("rst_no_pulse", pulses_a - p0, 32'd0);
    mon_en_a = 1'b1;

    send_a(8'h12);
    drain("drain_after_rst");

    check_eq("total_pulses_a", pulses_a, 32'd6);
    check_eq("total_pulses_b", pulses_b, 32'd1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
